// File: rtl/ccsds123_header_inserter.sv
// Framing stage after ccsds123_top: prepends a fixed image header word to each compressed frame.
// Optional trailer {frame index, payload word count} is enabled by defining CCSDS123_TRAILER_EN.
module ccsds123_header_inserter #(
  parameter int BUS_WIDTH = 64,
  parameter int NX        = 500,
  parameter int NY        = 500,
  parameter int NZ        = 100
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic [BUS_WIDTH-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  input  logic                 s_axis_tlast,
  output logic                 s_axis_tready,
  output logic [BUS_WIDTH-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  input  logic                 m_axis_tready,
  output logic [31:0]          frame_count
);

  if (BUS_WIDTH != 64) begin : g_bad_width
    $error("ccsds123_header_inserter: only BUS_WIDTH=64 is supported");
  end
  if (NX < 1 || NX > 65536 || NY < 1 || NY > 65536 || NZ < 1 || NZ > 65536) begin : g_bad_dims
    $error("ccsds123_header_inserter: NX/NY/NZ must lie in 1..65536");
  end

  localparam logic [BUS_WIDTH-1:0] HEADER_WORD =
    {16'hC123, 16'(NX - 1), 16'(NY - 1), 16'(NZ - 1)};

  localparam logic [1:0] ST_HEADER  = 2'd0;
  localparam logic [1:0] ST_PAYLOAD = 2'd1;
`ifdef CCSDS123_TRAILER_EN
  localparam logic [1:0] ST_TRAILER = 2'd2;
`endif

  logic [1:0]  state;
  logic [31:0] beat_cnt;
  logic        slot_free;
  logic        in_accept;
  logic        out_final;

  // The output register may take a new word when it is empty or being drained this cycle.
  assign slot_free     = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = (state == ST_PAYLOAD) && slot_free;
  assign in_accept     = s_axis_tvalid && s_axis_tready;
  assign out_final     = m_axis_tvalid && m_axis_tready && m_axis_tlast;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= ST_HEADER;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      case (state)
        ST_HEADER: begin
          // Header is only produced once the compressor actually offers payload.
          if (s_axis_tvalid && slot_free) begin
            m_axis_tdata  <= HEADER_WORD;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= 1'b0;
            state         <= ST_PAYLOAD;
          end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
          end
        end
        ST_PAYLOAD: begin
          if (in_accept) begin
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tvalid <= 1'b1;
`ifdef CCSDS123_TRAILER_EN
            m_axis_tlast  <= 1'b0;
            if (s_axis_tlast) state <= ST_TRAILER;
`else
            m_axis_tlast  <= s_axis_tlast;
            if (s_axis_tlast) state <= ST_HEADER;
`endif
          end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
          end
        end
`ifdef CCSDS123_TRAILER_EN
        ST_TRAILER: begin
          if (slot_free) begin
            m_axis_tdata  <= {frame_count, beat_cnt};
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= 1'b1;
            state         <= ST_HEADER;
          end
        end
`endif
        default: begin
          state <= ST_HEADER;
        end
      endcase
    end
  end

  // Both counters advance on the final output handshake; the beat count restarts for the next frame.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      frame_count <= '0;
      beat_cnt    <= '0;
    end else begin
      if (out_final) begin
        frame_count <= frame_count + 32'd1;
        beat_cnt    <= in_accept ? 32'd1 : 32'd0;
      end else if (in_accept) begin
        beat_cnt <= beat_cnt + 32'd1;
      end
    end
  end

`ifndef SYNTHESIS
  a_hold_stable : assert property (@(posedge clk) disable iff (!aresetn)
    (m_axis_tvalid && !m_axis_tready) |=>
      (m_axis_tvalid && $stable(m_axis_tdata) && $stable(m_axis_tlast)));
`endif

endmodule

// File: tb/tb_ccsds123_header_inserter.sv
// Directed self-checking bench for ccsds123_header_inserter (NX=4, NY=2, NZ=3).
// Expectations follow CCSDS123_TRAILER_EN when it is defined for the build.
module tb_ccsds123_header_inserter;

  localparam int NX = 4;
  localparam int NY = 2;
  localparam int NZ = 3;
  localparam logic [63:0] HDR = 64'hC123_0003_0001_0002;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [63:0] s_tdata;
  logic        s_tvalid;
  logic        s_tlast;
  logic        s_tready;
  logic [63:0] m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready;
  logic [31:0] frame_count;

  int checks = 0;
  int errors = 0;

  logic [64:0] out_q[$];
  int          cyc_q[$];
  int          in_acc = 0;
  int          stab_viol = 0;
  int          cyc = 0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data = '0;
  logic        prev_last = 1'b0;

  always #5 clk = ~clk;

  ccsds123_header_inserter #(.BUS_WIDTH(64), .NX(NX), .NY(NY), .NZ(NZ)) dut (
    .clk(clk),
    .aresetn(aresetn),
    .s_axis_tdata(s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tlast(m_tlast),
    .m_axis_tready(m_tready),
    .frame_count(frame_count)
  );

  // Inputs only change at posedge+1, so the negedge view predicts the next edge's handshakes.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (aresetn) begin
      if (m_tvalid && m_tready) begin
        out_q.push_back({m_tlast, m_tdata});
        cyc_q.push_back(cyc);
      end
      if (s_tvalid && s_tready) in_acc <= in_acc + 1;
      if (prev_stall && !(m_tvalid && m_tdata == prev_data && m_tlast == prev_last))
        stab_viol <= stab_viol + 1;
      prev_stall <= m_tvalid && !m_tready;
      prev_data  <= m_tdata;
      prev_last  <= m_tlast;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  task automatic do_reset();
    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
    m_tready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    aresetn = 1'b1;
  endtask

  task automatic drive_word(input logic [63:0] d, input logic last, output bit ok);
    int  n = 0;
    bit  acc = 0;
    s_tdata  = d;
    s_tlast  = last;
    s_tvalid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = s_tvalid && s_tready;
      @(posedge clk);
      #1;
      n++;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    ok = acc;
  endtask

  task automatic wait_outs(input int target, output bit ok);
    int n = 0;
    while (out_q.size() < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    ok = (out_q.size() >= target);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
    m_tready = 1'b0;
    @(negedge clk);
    checks++;
    if (m_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tvalid got %0b want 0", m_tvalid); end
    checks++;
    if (m_tdata !== 64'd0) begin errors++; $display("[TB] FAIL reset_tdata got %h want 0", m_tdata); end
    checks++;
    if (m_tlast !== 1'b0) begin errors++; $display("[TB] FAIL reset_tlast got %0b want 0", m_tlast); end
    checks++;
    if (s_tready !== 1'b0) begin errors++; $display("[TB] FAIL reset_s_tready got %0b want 0", s_tready); end
    checks++;
    if (frame_count !== 32'd0) begin errors++; $display("[TB] FAIL reset_frame_count got %0d want 0", frame_count); end
    @(posedge clk);
    #1;
    aresetn = 1'b1;
  endtask

  task automatic test_basic_frame();
    logic [64:0] exp[$];
    logic [64:0] got;
    int  base;
    bit  ok, all_ok;
    do_reset();
    m_tready = 1'b1;
    base = out_q.size();
    all_ok = 1;
    drive_word(64'hAAAA_0000_0000_000A, 1'b0, ok); all_ok &= ok;
    drive_word(64'hBBBB_0000_0000_000B, 1'b0, ok); all_ok &= ok;
    drive_word(64'hCCCC_0000_0000_000C, 1'b1, ok); all_ok &= ok;
    exp.push_back({1'b0, HDR});
    exp.push_back({1'b0, 64'hAAAA_0000_0000_000A});
    exp.push_back({1'b0, 64'hBBBB_0000_0000_000B});
`ifdef CCSDS123_TRAILER_EN
    exp.push_back({1'b0, 64'hCCCC_0000_0000_000C});
    exp.push_back({1'b1, 64'h0000_0000_0000_0003});
`else
    exp.push_back({1'b1, 64'hCCCC_0000_0000_000C});
`endif
    wait_outs(base + exp.size(), ok);
    checks++;
    if (!(ok && all_ok)) begin errors++; $display("[TB] FAIL basic_timeout got %0d words want %0d", out_q.size() - base, exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      got = (base + i < out_q.size()) ? out_q[base + i] : 'x;
      checks++;
      if (got !== exp[i]) begin errors++; $display("[TB] FAIL basic_word%0d got %h want %h", i, got, exp[i]); end
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_q.size() != base + exp.size()) begin errors++; $display("[TB] FAIL basic_extra got %0d words want %0d", out_q.size() - base, exp.size()); end
    checks++;
    if (frame_count !== 32'd1) begin errors++; $display("[TB] FAIL basic_frame_count got %0d want 1", frame_count); end
  endtask

  task automatic test_back_to_back();
    logic [64:0] exp[$];
    logic [64:0] got;
    int  base;
    bit  ok, all_ok, gap_ok;
    do_reset();
    m_tready = 1'b1;
    base = out_q.size();
    all_ok = 1;
    drive_word(64'h0101_0101_0101_0101, 1'b0, ok); all_ok &= ok;
    drive_word(64'h0202_0202_0202_0202, 1'b1, ok); all_ok &= ok;
    drive_word(64'h0303_0303_0303_0303, 1'b0, ok); all_ok &= ok;
    drive_word(64'h0404_0404_0404_0404, 1'b1, ok); all_ok &= ok;
    exp.push_back({1'b0, HDR});
    exp.push_back({1'b0, 64'h0101_0101_0101_0101});
`ifdef CCSDS123_TRAILER_EN
    exp.push_back({1'b0, 64'h0202_0202_0202_0202});
    exp.push_back({1'b1, 64'h0000_0000_0000_0002});
`else
    exp.push_back({1'b1, 64'h0202_0202_0202_0202});
`endif
    exp.push_back({1'b0, HDR});
    exp.push_back({1'b0, 64'h0303_0303_0303_0303});
`ifdef CCSDS123_TRAILER_EN
    exp.push_back({1'b0, 64'h0404_0404_0404_0404});
    exp.push_back({1'b1, 64'h0000_0001_0000_0002});
`else
    exp.push_back({1'b1, 64'h0404_0404_0404_0404});
`endif
    wait_outs(base + exp.size(), ok);
    checks++;
    if (!(ok && all_ok)) begin errors++; $display("[TB] FAIL b2b_timeout got %0d words want %0d", out_q.size() - base, exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      got = (base + i < out_q.size()) ? out_q[base + i] : 'x;
      checks++;
      if (got !== exp[i]) begin errors++; $display("[TB] FAIL b2b_word%0d got %h want %h", i, got, exp[i]); end
    end
    gap_ok = ok;
    for (int i = 1; i < exp.size() && ok; i++) begin
      if (cyc_q[base + i] - cyc_q[base + i - 1] != 1) gap_ok = 0;
    end
    checks++;
    if (!gap_ok) begin errors++; $display("[TB] FAIL b2b_gap got gap_free=%0b want 1", gap_ok); end
    checks++;
    if (frame_count !== 32'd2) begin errors++; $display("[TB] FAIL b2b_frame_count got %0d want 2", frame_count); end
  endtask

  task automatic test_one_word();
    logic [64:0] exp[$];
    logic [64:0] got;
    int  base;
    bit  ok, all_ok;
    do_reset();
    m_tready = 1'b1;
    base = out_q.size();
    drive_word(64'hDEAD_BEEF_0000_0001, 1'b1, all_ok);
    exp.push_back({1'b0, HDR});
`ifdef CCSDS123_TRAILER_EN
    exp.push_back({1'b0, 64'hDEAD_BEEF_0000_0001});
    exp.push_back({1'b1, 64'h0000_0000_0000_0001});
`else
    exp.push_back({1'b1, 64'hDEAD_BEEF_0000_0001});
`endif
    wait_outs(base + exp.size(), ok);
    checks++;
    if (!(ok && all_ok)) begin errors++; $display("[TB] FAIL one_timeout got %0d words want %0d", out_q.size() - base, exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      got = (base + i < out_q.size()) ? out_q[base + i] : 'x;
      checks++;
      if (got !== exp[i]) begin errors++; $display("[TB] FAIL one_word%0d got %h want %h", i, got, exp[i]); end
    end
    checks++;
    if (frame_count !== 32'd1) begin errors++; $display("[TB] FAIL one_frame_count got %0d want 1", frame_count); end
  endtask

  task automatic test_header_stall();
    logic [64:0] exp[$];
    logic [64:0] got;
    int  base, base_in, base_viol;
    bit  ok, all_ok;
    do_reset();
    base = out_q.size();
    base_in = in_acc;
    base_viol = stab_viol;
    m_tready = 1'b0;
    s_tdata  = 64'h5555_AAAA_5555_AAAA;
    s_tlast  = 1'b1;
    s_tvalid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== HDR || m_tlast !== 1'b0) begin
      errors++; $display("[TB] FAIL hstall_hold got v=%0b d=%h l=%0b want v=1 d=%h l=0", m_tvalid, m_tdata, m_tlast, HDR);
    end
    checks++;
    if (s_tready !== 1'b0) begin errors++; $display("[TB] FAIL hstall_s_tready got %0b want 0", s_tready); end
    checks++;
    if (in_acc != base_in) begin errors++; $display("[TB] FAIL hstall_accepts got %0d want 0", in_acc - base_in); end
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    drive_word(64'h5555_AAAA_5555_AAAA, 1'b1, all_ok);
    exp.push_back({1'b0, HDR});
`ifdef CCSDS123_TRAILER_EN
    exp.push_back({1'b0, 64'h5555_AAAA_5555_AAAA});
    exp.push_back({1'b1, 64'h0000_0000_0000_0001});
`else
    exp.push_back({1'b1, 64'h5555_AAAA_5555_AAAA});
`endif
    wait_outs(base + exp.size(), ok);
    checks++;
    if (!(ok && all_ok)) begin errors++; $display("[TB] FAIL hstall_timeout got %0d words want %0d", out_q.size() - base, exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      got = (base + i < out_q.size()) ? out_q[base + i] : 'x;
      checks++;
      if (got !== exp[i]) begin errors++; $display("[TB] FAIL hstall_word%0d got %h want %h", i, got, exp[i]); end
    end
    checks++;
    if (stab_viol != base_viol) begin errors++; $display("[TB] FAIL hstall_stable got %0d violations want 0", stab_viol - base_viol); end
  endtask

  task automatic test_random_stall();
    localparam int N = 1000;
    logic [63:0] words[N];
    logic [64:0] exp[$];
    logic [64:0] got;
    int  base, base_viol, idx, stall, target;
    bit  acc;
    do_reset();
    base = out_q.size();
    base_viol = stab_viol;
    for (int i = 0; i < N; i++) words[i] = {$urandom, $urandom};
    exp.push_back({1'b0, HDR});
    for (int i = 0; i < N - 1; i++) exp.push_back({1'b0, words[i]});
`ifdef CCSDS123_TRAILER_EN
    exp.push_back({1'b0, words[N-1]});
    exp.push_back({1'b1, 32'd0, 32'(N)});
`else
    exp.push_back({1'b1, words[N-1]});
`endif
    target = base + exp.size();
    idx = 0;
    stall = 0;
    for (int c = 0; c < 20000; c++) begin
      if (idx == N && out_q.size() >= target) break;
      if (stall > 0) begin
        m_tready = 1'b0;
        stall--;
      end else if ($urandom_range(39, 0) == 0) begin
        stall = $urandom_range(40, 20) - 1;
        m_tready = 1'b0;
      end else begin
        m_tready = 1'b1;
      end
      if (!s_tvalid && idx < N && $urandom_range(3, 0) != 0) begin
        s_tvalid = 1'b1;
        s_tdata  = words[idx];
        s_tlast  = (idx == N - 1);
      end
      @(negedge clk);
      acc = s_tvalid && s_tready;
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
      end
    end
    m_tready = 1'b1;
    s_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (idx != N || out_q.size() != target) begin
      errors++; $display("[TB] FAIL rand_count got in=%0d out=%0d want in=%0d out=%0d", idx, out_q.size() - base, N, exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      got = (base + i < out_q.size()) ? out_q[base + i] : 'x;
      checks++;
      if (got !== exp[i]) begin errors++; $display("[TB] FAIL rand_word%0d got %h want %h", i, got, exp[i]); end
    end
    checks++;
    if (stab_viol != base_viol) begin errors++; $display("[TB] FAIL rand_stable got %0d violations want 0", stab_viol - base_viol); end
    checks++;
    if (frame_count !== 32'd1) begin errors++; $display("[TB] FAIL rand_frame_count got %0d want 1", frame_count); end
  endtask

  task automatic test_reset_midframe();
    logic [64:0] got;
    int  base;
    bit  ok, all_ok;
    do_reset();
    m_tready = 1'b1;
    all_ok = 1;
    for (int i = 0; i < 5; i++) begin
      drive_word(64'h7000_0000_0000_0000 + 64'(i), 1'b0, ok);
      all_ok &= ok;
    end
    m_tready = 1'b0;
    s_tdata  = 64'h7000_0000_0000_0005;
    s_tlast  = 1'b0;
    s_tvalid = 1'b1;
    @(negedge clk);
    checks++;
    if (!all_ok || m_tvalid !== 1'b1 || m_tdata !== 64'h7000_0000_0000_0004 || s_tready !== 1'b0) begin
      errors++; $display("[TB] FAIL midrst_held got v=%0b d=%h rdy=%0b want v=1 d=7000000000000004 rdy=0", m_tvalid, m_tdata, s_tready);
    end
    @(posedge clk);
    #1;
    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (m_tvalid !== 1'b0 || m_tdata !== 64'd0 || m_tlast !== 1'b0) begin
      errors++; $display("[TB] FAIL midrst_outputs got v=%0b d=%h l=%0b want all 0", m_tvalid, m_tdata, m_tlast);
    end
    checks++;
    if (s_tready !== 1'b0 || frame_count !== 32'd0) begin
      errors++; $display("[TB] FAIL midrst_status got rdy=%0b fc=%0d want 0 0", s_tready, frame_count);
    end
    @(posedge clk);
    #1;
    aresetn  = 1'b1;
    m_tready = 1'b1;
    base = out_q.size();
    drive_word(64'h7000_0000_0000_0006, 1'b1, all_ok);
    checks++;
    if (frame_count !== 32'd0) begin errors++; $display("[TB] FAIL midrst_fc_after got %0d want 0", frame_count); end
    wait_outs(base + 2, ok);
    got = (base < out_q.size()) ? out_q[base] : 'x;
    checks++;
    if (!(ok && all_ok) || got !== {1'b0, HDR}) begin
      errors++; $display("[TB] FAIL midrst_restart got %h want %h", got, {1'b0, HDR});
    end
    got = (base + 1 < out_q.size()) ? out_q[base + 1] : 'x;
    checks++;
    if (got[63:0] !== 64'h7000_0000_0000_0006) begin
      errors++; $display("[TB] FAIL midrst_first_word got %h want 7000000000000006", got[63:0]);
    end
  endtask

  initial begin
    $display("[TB] ccsds123_header_inserter bench start");
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_one_word();
    test_header_stall();
    test_random_stall();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
